// File: rtl/semimips_pkg.sv
// ============================================================================
// Module  : semimips_pkg
// Brief   : Shared constants, FSM encoding and helpers for the fetch stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package semimips_pkg;

    localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] c_NOP_WORD         = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Brief   : Up-counter that sticks at all-ones, with synchronous clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module  : fetch_stage
// Brief   : Instruction fetch: PC register, IF/ID latch, perf counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_stage
    import semimips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        pcload,
    input  logic [31:0] pctarget,
    input  logic        ifidflush,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pcplus4,
    output logic        ifid_valid,
    output logic        misalign,
    output logic [15:0] fetch_count,
    output logic [15:0] flush_count
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic [31:0]  r_pcplus4;
    logic         r_valid;
    logic         r_misalign;

    logic         w_boot;
    logic [31:0]  w_pc_plus4;
    logic         w_fetch_inc;
    logic         w_flush_inc;

    assign w_boot      = (r_state == BOOT);
    assign w_pc_plus4  = r_pc + 32'd4;
    // Control inputs only take effect once out of BOOT and out of reset.
    assign w_fetch_inc = !reset && !w_boot && !ifidflush && !stall;
    assign w_flush_inc = !reset && !w_boot && ifidflush && r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_instr    <= c_NOP_WORD;
            r_pcplus4  <= 32'd0;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
        end else if (w_boot) begin
            r_state    <= RUN;
            r_pc       <= RESET_PC;
            r_instr    <= c_NOP_WORD;
            r_pcplus4  <= 32'd0;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                RUN:     if (stall && !pcload) r_state <= HOLD;
                HOLD:    if (!stall || pcload) r_state <= RUN;
                default: r_state <= BOOT;
            endcase

            if (pcload) begin
                r_pc <= word_align(pctarget);
            end else if (!stall) begin
                r_pc <= w_pc_plus4;
            end

            r_misalign <= pcload && (pctarget[1:0] != 2'b00);

            if (ifidflush) begin
                r_instr   <= c_NOP_WORD;
                r_pcplus4 <= 32'd0;
                r_valid   <= 1'b0;
            end else if (!stall) begin
                r_instr   <= imem_data;
                r_pcplus4 <= w_pc_plus4;
                r_valid   <= 1'b1;
            end
        end
    end

    sat_counter #(.WIDTH(16)) u_fetch_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (w_fetch_inc),
        .count (fetch_count)
    );

    sat_counter #(.WIDTH(16)) u_flush_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (w_flush_inc),
        .count (flush_count)
    );

    assign imem_addr    = r_pc;
    assign pc           = r_pc;
    assign ifid_instr   = r_instr;
    assign ifid_pcplus4 = r_pcplus4;
    assign ifid_valid   = r_valid;
    assign misalign     = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module  : tb_fetch_stage
// Brief   : Directed self-checking bench for fetch_stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;
    import semimips_pkg::*;

    localparam logic [31:0] c_IMEM_TAG = 32'hDEAD_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        pcload;
    logic [31:0] pctarget;
    logic        ifidflush;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pcplus4;
    logic        ifid_valid;
    logic        misalign;
    logic [15:0] fetch_count;
    logic [15:0] flush_count;

    int checks = 0;
    int errors = 0;

    // Instruction memory: each word is its own address tagged in the upper half.
    assign imem_data = imem_addr ^ c_IMEM_TAG;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .pcload       (pcload),
        .pctarget     (pctarget),
        .ifidflush    (ifidflush),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .pc           (pc),
        .ifid_instr   (ifid_instr),
        .ifid_pcplus4 (ifid_pcplus4),
        .ifid_valid   (ifid_valid),
        .misalign     (misalign),
        .fetch_count  (fetch_count),
        .flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h exp %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".pc"},      pc, 32'h0);
        check({tag, ".instr"},   ifid_instr, 32'h0);
        check({tag, ".pcplus4"}, ifid_pcplus4, 32'h0);
        check({tag, ".valid"},   {31'b0, ifid_valid}, 32'h0);
        check({tag, ".misal"},   {31'b0, misalign}, 32'h0);
        check({tag, ".fetch"},   {16'b0, fetch_count}, 32'h0);
        check({tag, ".flush"},   {16'b0, flush_count}, 32'h0);
        check({tag, ".state"},   {30'b0, dut.r_state}, {30'b0, BOOT});
    endtask

    task automatic clear_inputs();
        stall     = 1'b0;
        pcload    = 1'b0;
        pctarget  = 32'h0;
        ifidflush = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        step();
        check_reset_values("rst");
        check("imem_addr", imem_addr, 32'h0);

        // Sequential fetch from reset
        reset = 1'b0;
        step();
        check("seq1.pc", pc, 32'h0);
        check("seq1.valid", {31'b0, ifid_valid}, 32'h0);
        check("seq1.state", {30'b0, dut.r_state}, {30'b0, RUN});
        step();
        check("seq2.pc", pc, 32'h4);
        check("seq2.valid", {31'b0, ifid_valid}, 32'h1);
        check("seq2.instr", ifid_instr, 32'hDEAD_0000);
        check("seq2.pcplus4", ifid_pcplus4, 32'h4);
        step();
        check("seq3.pc", pc, 32'h8);
        step();
        check("seq4.pc", pc, 32'hC);
        check("seq4.fetch", {16'b0, fetch_count}, 32'd3);

        // Stall at pc=8
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (3) step();
        check("pre_stall.pc", pc, 32'h8);
        check("pre_stall.instr", ifid_instr, 32'hDEAD_0004);
        stall = 1'b1;
        step();
        check("stall1.pc", pc, 32'h8);
        check("stall1.instr", ifid_instr, 32'hDEAD_0004);
        check("stall1.pcplus4", ifid_pcplus4, 32'h8);
        check("stall1.fetch", {16'b0, fetch_count}, 32'd2);
        check("stall1.state", {30'b0, dut.r_state}, {30'b0, HOLD});
        step();
        check("stall2.pc", pc, 32'h8);
        check("stall2.instr", ifid_instr, 32'hDEAD_0004);
        check("stall2.state", {30'b0, dut.r_state}, {30'b0, HOLD});
        stall = 1'b0;
        step();
        check("unstall.state", {30'b0, dut.r_state}, {30'b0, RUN});
        check("unstall.pc", pc, 32'hC);
        check("unstall.instr", ifid_instr, 32'hDEAD_0008);
        check("unstall.fetch", {16'b0, fetch_count}, 32'd3);

        // Redirect with flush of a valid IF/ID entry
        pcload    = 1'b1;
        pctarget  = 32'h40;
        ifidflush = 1'b1;
        step();
        clear_inputs();
        check("redir.pc", pc, 32'h40);
        check("redir.valid", {31'b0, ifid_valid}, 32'h0);
        check("redir.instr", ifid_instr, 32'h0);
        check("redir.flush", {16'b0, flush_count}, 32'd1);
        check("redir.fetch", {16'b0, fetch_count}, 32'd3);
        check("redir.misal", {31'b0, misalign}, 32'h0);
        step();
        check("redir2.pc", pc, 32'h44);
        check("redir2.instr", ifid_instr, 32'hDEAD_0040);
        check("redir2.valid", {31'b0, ifid_valid}, 32'h1);

        // Misaligned redirect
        pcload   = 1'b1;
        pctarget = 32'h43;
        step();
        clear_inputs();
        check("misal.pc", pc, 32'h40);
        check("misal.pulse", {31'b0, misalign}, 32'h1);
        check("misal.instr", ifid_instr, 32'hDEAD_0044);
        check("misal.pcplus4", ifid_pcplus4, 32'h48);
        step();
        check("misal2.pulse", {31'b0, misalign}, 32'h0);
        check("misal2.pc", pc, 32'h44);

        // PC wrap
        pcload   = 1'b1;
        pctarget = 32'hFFFF_FFFC;
        step();
        clear_inputs();
        check("wrap.pc", pc, 32'hFFFF_FFFC);
        step();
        check("wrap2.pc", pc, 32'h0);
        check("wrap2.instr", ifid_instr, 32'h2152_FFFC);
        check("wrap2.pcplus4", ifid_pcplus4, 32'h0);

        // Stall and pcload together: pc redirects, IF/ID holds
        stall    = 1'b1;
        pcload   = 1'b1;
        pctarget = 32'h80;
        step();
        clear_inputs();
        check("both.pc", pc, 32'h80);
        check("both.instr", ifid_instr, 32'h2152_FFFC);
        check("both.state", {30'b0, dut.r_state}, {30'b0, RUN});

        // Reset in the middle of a stall with a redirect pending
        stall = 1'b1;
        step();
        check("pre_rst.state", {30'b0, dut.r_state}, {30'b0, HOLD});
        reset     = 1'b1;
        pcload    = 1'b1;
        pctarget  = 32'h101;
        ifidflush = 1'b1;
        step();
        check_reset_values("midrst");
        reset = 1'b0;
        clear_inputs();

        // Fetch counter saturation
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 70000 && fetch_count != 16'hFFFF; i++) begin
            step();
        end
        check("sat.reach", {16'b0, fetch_count}, 32'h0000_FFFF);
        step();
        step();
        check("sat.hold", {16'b0, fetch_count}, 32'h0000_FFFF);
        check("sat.flush", {16'b0, flush_count}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
